single_adder: RTL and testbench
===============================

SINGLE_ADDER -- requirements
Module: single_adder

Interface
REQ-001 Parameter: N, 32, operand and result width in bits; legal range 4..64, multiple of 4.
REQ-002 Port: clk  input  1  system clock, rising-edge active.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: A  input  N  first unsigned/two's-complement operand.
REQ-005 Port: B  input  N  second unsigned/two's-complement operand.
REQ-006 Port: Y  output  N  registered sum A+B modulo 2^N.
REQ-007 Port: carry_out  output  1  registered unsigned carry out of bit N-1.
REQ-008 Port: overflow  output  1  registered signed overflow flag.
REQ-009 Port: zero  output  1  registered flag, 1 when the registered Y is all zeros.
REQ-010 The block SHALL have one clock, clk, and an asynchronous, active-high reset, rst.

Function
REQ-011 The sum SHALL be computed combinationally as A+B with carry-in 0, truncated to N bits; bits above N-1 go only to carry_out.
REQ-012 The sum logic SHALL be a carry-lookahead structure: 4-bit groups with per-bit generate/propagate and a group-level lookahead carry chain; no vendor adder primitive.
REQ-013 Y, carry_out, overflow and zero SHALL be registered on the rising edge of clk; latency is exactly 1 cycle from A/B being stable before an edge to the outputs updating.
REQ-014 A new result SHALL be captured on every rising edge; there is no enable or handshake, and throughput is one sum per cycle.
REQ-015 carry_out SHALL equal bit N of the (N+1)-bit unsigned sum.
REQ-016 overflow SHALL be 1 iff A[N-1]==B[N-1] and Y[N-1]!=A[N-1] for the same operand pair.
REQ-017 zero SHALL be computed from the same sum captured into Y, so it is never one cycle behind Y.
REQ-018 The addition SHALL be commutative; swapping A and B yields identical Y and flags.
REQ-019 Wrap-around: all-ones + 1 SHALL give Y=0, carry_out=1, zero=1, overflow=0.
REQ-020 Outputs SHALL hold their last registered value between clock edges regardless of input changes.
REQ-021 X or Z on A/B is not supported; behaviour is defined only for 0/1 inputs.

Reset
REQ-022 While rst=1, Y SHALL be 0, carry_out=0, overflow=0 and zero=1, all forced asynchronously without waiting for clk.
REQ-023 Reset asserted mid-operation SHALL discard the in-flight result immediately.
REQ-024 On the first rising clk edge with rst=0 after deassertion, the outputs SHALL capture the sum of the current A and B.
REQ-025 If rst deasserts on the same edge as a clk rise, the outputs SHALL remain at reset values for that edge.

Verification
REQ-026 Scenario: reset asserted, then A=0xE59F1020, B=0x0, one edge -> Y=0xE59F1020, carry_out=0, overflow=0, zero=0.
REQ-027 Scenario: A=0xE59F1020, B=0x4, then swapped (A=0x4, B=0xE59F1020), one edge each -> Y=0xE59F1024 both times, flags identical.
REQ-028 Scenario: A=0x28A44EAF, B=0xA895D275 -> after 1 edge Y=0xD13A2124, carry_out=0, overflow=0, zero=0; before that edge Y still shows the previous result.
REQ-029 Scenario: A=0xFFFFFFFF, B=0x1 -> Y=0x00000000, carry_out=1, zero=1, overflow=0; A=0x7FFFFFFF, B=0x1 -> Y=0x80000000, overflow=1, carry_out=0.
REQ-030 Scenario: rst pulsed high between clock edges while Y=0xD13A2124 -> Y=0 and zero=1 immediately; after release, the next edge captures the current A+B.
REQ-031 Scenario: 1000 random A/B pairs, one per cycle -> each Y equals (A+B) mod 2^32 one cycle later, with carry_out and overflow matching the reference model.

Source files
------------

// File: rtl/single_adder.sv
// Registered N-bit adder built from 4-bit carry-lookahead groups, with
// unsigned carry, signed overflow and zero flags captured alongside the sum.
module single_adder #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Y,
    output logic         carry_out,
    output logic         overflow,
    output logic         zero
);

    localparam int G = N / 4;

    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N-1:0] carry;
    logic [G-1:0] grp_gen;
    logic [G-1:0] grp_prop;
    logic [G:0]   grp_carry;
    logic [N-1:0] sum;
    logic         sum_carry;
    logic         sum_overflow;

    always_comb begin
        gen       = A & B;
        prop      = A ^ B;
        grp_gen   = '0;
        grp_prop  = '0;
        grp_carry = '0;
        carry     = '0;

        for (int k = 0; k < G; k++) begin
            grp_gen[k]  = gen[4*k+3]
                        | (prop[4*k+3] & gen[4*k+2])
                        | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                        | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]);
            grp_prop[k] = prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & prop[4*k];
        end

        // Group-level lookahead chain; carry-in to bit 0 is always zero.
        for (int k = 0; k < G; k++) begin
            grp_carry[k+1] = grp_gen[k] | (grp_prop[k] & grp_carry[k]);
        end

        for (int k = 0; k < G; k++) begin
            carry[4*k]   = grp_carry[k];
            carry[4*k+1] = gen[4*k]
                         | (prop[4*k] & grp_carry[k]);
            carry[4*k+2] = gen[4*k+1]
                         | (prop[4*k+1] & gen[4*k])
                         | (prop[4*k+1] & prop[4*k] & grp_carry[k]);
            carry[4*k+3] = gen[4*k+2]
                         | (prop[4*k+2] & gen[4*k+1])
                         | (prop[4*k+2] & prop[4*k+1] & gen[4*k])
                         | (prop[4*k+2] & prop[4*k+1] & prop[4*k] & grp_carry[k]);
        end

        sum          = prop ^ carry;
        sum_carry    = grp_carry[G];
        // Carry into the sign bit differing from carry out of it marks signed overflow.
        sum_overflow = carry[N-1] ^ grp_carry[G];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y         <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
        end else begin
            Y         <= sum;
            carry_out <= sum_carry;
            overflow  <= sum_overflow;
            zero      <= (sum == '0);
        end
    end

endmodule

// File: tb/tb_single_adder.sv
// Directed and random-vector bench for single_adder; expected values are
// hand-computed constants or a plain wide-addition reference.
module tb_single_adder;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] Y;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    int checks   = 0;
    int failures = 0;

    single_adder #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .Y         (Y),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic expect_out(input string tag, input logic [N-1:0] y,
                              input logic co, input logic ov, input logic z);
        check({tag, ".y"},  64'(Y), 64'(y));
        check({tag, ".co"}, 64'(carry_out), 64'(co));
        check({tag, ".ov"}, 64'(overflow), 64'(ov));
        check({tag, ".z"},  64'(zero), 64'(z));
    endtask

    task automatic apply(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        A = a;
        B = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        logic [N:0]   ref_sum;
        logic         ref_ov;

        rst = 1'b1;
        A   = '0;
        B   = '0;
        #3;
        expect_out("reset", 32'h0, 1'b0, 1'b0, 1'b1);

        @(negedge clk);
        rst = 1'b0;
        apply(32'hE59F1020, 32'h0);
        expect_out("first_after_reset", 32'hE59F1020, 1'b0, 1'b0, 1'b0);

        apply(32'hE59F1020, 32'h4);
        expect_out("ab", 32'hE59F1024, 1'b0, 1'b0, 1'b0);
        apply(32'h4, 32'hE59F1020);
        expect_out("ba", 32'hE59F1024, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        A = 32'h28A44EAF;
        B = 32'hA895D275;
        #2;
        check("hold_before_edge.y", 64'(Y), 64'h0E59F1024);
        @(posedge clk);
        #1;
        expect_out("mixed", 32'hD13A2124, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset pulse between edges, then recapture.
        #2;
        rst = 1'b1;
        #1;
        expect_out("async_reset", 32'h0, 1'b0, 1'b0, 1'b1);
        A = 32'h1;
        B = 32'h2;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        expect_out("after_release", 32'h3, 1'b0, 1'b0, 1'b0);

        apply(32'hFFFFFFFF, 32'h1);
        expect_out("wrap", 32'h0, 1'b1, 1'b0, 1'b1);
        apply(32'h7FFFFFFF, 32'h1);
        expect_out("pos_ovf", 32'h80000000, 1'b0, 1'b1, 1'b0);
        apply(32'h80000000, 32'h80000000);
        expect_out("neg_ovf", 32'h0, 1'b1, 1'b1, 1'b1);
        apply(32'hFFFFFFFF, 32'hFFFFFFFF);
        expect_out("all_ones", 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
        apply(32'h0F0F0F0F, 32'h01010101);
        expect_out("group_carry", 32'h10101010, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 50 == 0) rb = ~ra + 32'(i % 3);
            apply(ra, rb);
            ref_sum = {1'b0, ra} + {1'b0, rb};
            ref_ov  = (ra[N-1] == rb[N-1]) && (ref_sum[N-1] != ra[N-1]);
            expect_out("random", ref_sum[N-1:0], ref_sum[N], ref_ov,
                       ref_sum[N-1:0] == '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
